datapath: RTL and testbench
===========================

DATAPATH -- requirements
Module: datapath

Interface
REQ-001 Parameter BITS, default 32, data word width.
REQ-002 Parameter REGISTERS, default 16, number of general-purpose registers R0..R(REGISTERS-1).
REQ-003 Clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 GPRin  in  REGISTERS  per-register load enable; bit i loads Ri from bus.
REQ-006 PCin, IRin, RYin, RZin, MARin, HIin, LOin, MDRin  in  1 each  load enables for PC, IR, RY, RZ, MAR, HI, LO, MDR.
REQ-007 Read  in  1  MDR input select: 1 = Mdatain, 0 = bus.
REQ-008 MDRout, LOout, HIout, Zhighout, Zlowout, PCout  in  1 each  bus drive selects.
REQ-009 GPRout  in  REGISTERS  bit i drives Ri onto bus.
REQ-010 ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT, IncPC  in  1 each  ALU operation selects.
REQ-011 Mdatain  in  BITS  memory data input.
REQ-012 regSelectStream  out  BITS*(REGISTERS+6)  slice i, bits [BITS*(i+1)-1 : BITS*i], is Ri for i < REGISTERS, then PC, IR, HI, LO, MAR, MDR in that order.
REQ-013 bus  out  BITS  current internal bus value.
REQ-014 MARVal, IRVal, LOVal, HIVal  out  BITS each  register contents.
REQ-015 RZVal  out  2*BITS  Z register contents; high half = Zhigh, low half = Zlow.

Function
REQ-016 Bus is a combinational mux; drive priority (highest first): GPRout[0..REGISTERS-1] (lowest index wins), PCout, MDRout, HIout, LOout, Zhighout, Zlowout.
REQ-017 Bus = 0 when no drive select is asserted.
REQ-018 Each register with its enable high loads on the rising edge and holds otherwise; Ri, PC, IR, RY, MAR, HI, LO load from bus.
REQ-019 MDR loads Mdatain when Read=1, else bus.
REQ-020 R0 is an ordinary writable register.
REQ-021 ALU is combinational: A = RY, B = bus; 2*BITS result C is loaded into RZ when RZin=1.
REQ-022 Op priority (highest first): IncPC, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT; none asserted gives C = 0.
REQ-023 Low half: IncPC B+1; ADD A+B; SUB A-B; AND A&B; OR A|B; NEGATE -B (two's complement); NOT ~B.
REQ-024 Shifts: SHR logical A>>B, SHL A<<B, ROR/ROL rotate A; amount = B mod BITS.
REQ-025 High half is 0 for every op except MUL and DIV; arithmetic wraps modulo 2^BITS.
REQ-026 MUL: C = signed A*B, full 2*BITS product.
REQ-027 DIV: low = signed A/B truncated toward zero, high = remainder with the sign of A.
REQ-028 DIV by zero: low = all ones, high = A.
REQ-029 Simultaneous load and drive of the same register in one cycle: the bus carries the old value; the register updates at the edge.

Reset
REQ-030 reset=1 at a rising edge clears every register (R0..R(REGISTERS-1), PC, IR, RY, RZ, MAR, MDR, HI, LO) to 0.
REQ-031 reset overrides all load enables in the same cycle.
REQ-032 After reset, all register outputs are 0 and bus = 0 with all drive selects low.

Verification
REQ-033 Load path: Read=1, MDRin=1, Mdatain=0x22; next cycle MDRout=1, GPRin[2]=1 -> R2 = 0x22; repeat 0x24 -> R4, 0x26 -> R5.
REQ-034 Fetch: PC=0; PCout, MARin, IncPC, RZin -> MAR = 0; Zlowout, PCin -> PC = 1; Read, MDRin with Mdatain=0x4A920000, then MDRout, IRin -> IRVal = 0x4A920000.
REQ-035 AND R5,R2,R4: GPRout[2], RYin; then GPRout[4], AND, RZin -> RZVal = 0x20; then Zlowout, GPRin[5] -> R5 = 0x20.
REQ-036 MUL/DIV: RY=-6, bus=4 -> MUL gives RZVal = 0xFFFFFFFF_FFFFFFE8; DIV gives low = 0xFFFFFFFF (-1), high = 0xFFFFFFFE (-2); B=0 -> low = 0xFFFFFFFF, high = A.
REQ-037 Shift/rotate: A=0x80000001, B=1 -> SHR 0x40000000, SHL 0x00000002, ROR 0xC0000000, ROL 0x00000003; B=33 matches B=1.
REQ-038 Reset mid-operation: registers loaded nonzero, reset=1 with load enables high -> all regSelectStream slices and RZVal = 0 after the edge.

Source files
------------

// File: rtl/datapath.sv
// ---------------------------------------------------------------------------
// datapath
//
// Single-bus CPU datapath: a bank of general-purpose registers plus PC, IR,
// RY, RZ (double width), MAR, HI, LO and MDR, all sharing one internal bus.
// The bus is a priority mux of the drive selects.  A combinational ALU takes
// A from RY and B from the bus and produces a 2*BITS result that RZ captures.
//
// Ports
//   Clock            rising-edge clock for all state
//   reset            synchronous active-high reset, clears every register
//   GPRin[i]         load Ri from bus
//   GPRout[i]        drive Ri onto bus (lowest index has highest priority)
//   PCin, IRin, RYin, RZin, MARin, HIin, LOin, MDRin   register load enables
//   Read             MDR source: 1 = Mdatain, 0 = bus
//   MDRout, LOout, HIout, Zhighout, Zlowout, PCout     bus drive selects
//   ADD .. IncPC     ALU operation selects (IncPC highest priority)
//   Mdatain          memory data input
//   regSelectStream  R0..R(REGISTERS-1), PC, IR, HI, LO, MAR, MDR packed
//                    from the least significant slice upward
//   bus              current bus value
//   MARVal, IRVal, LOVal, HIVal, RZVal   register contents
// ---------------------------------------------------------------------------
module datapath #(
    parameter int BITS      = 32,
    parameter int REGISTERS = 16
) (
    input  logic                               Clock,
    input  logic                               reset,
    input  logic [REGISTERS-1:0]               GPRin,
    input  logic                               PCin,
    input  logic                               IRin,
    input  logic                               RYin,
    input  logic                               RZin,
    input  logic                               MARin,
    input  logic                               HIin,
    input  logic                               LOin,
    input  logic                               MDRin,
    input  logic                               Read,
    input  logic                               MDRout,
    input  logic                               LOout,
    input  logic                               HIout,
    input  logic                               Zhighout,
    input  logic                               Zlowout,
    input  logic                               PCout,
    input  logic [REGISTERS-1:0]               GPRout,
    input  logic                               ADD,
    input  logic                               SUB,
    input  logic                               MUL,
    input  logic                               DIV,
    input  logic                               SHR,
    input  logic                               SHL,
    input  logic                               ROR,
    input  logic                               ROL,
    input  logic                               AND,
    input  logic                               OR,
    input  logic                               NEGATE,
    input  logic                               NOT,
    input  logic                               IncPC,
    input  logic [BITS-1:0]                    Mdatain,
    output logic [BITS*(REGISTERS+6)-1:0]      regSelectStream,
    output logic [BITS-1:0]                    bus,
    output logic [BITS-1:0]                    MARVal,
    output logic [BITS-1:0]                    IRVal,
    output logic [BITS-1:0]                    LOVal,
    output logic [BITS-1:0]                    HIVal,
    output logic [2*BITS-1:0]                  RZVal
);

    localparam logic [BITS-1:0] ONE      = BITS'(1);
    localparam logic [BITS-1:0] BITS_VAL = BITS'(BITS);

    // -----------------------------------------------------------------------
    // Arithmetic helpers
    // -----------------------------------------------------------------------

    // Full-width signed product; operands are sign-extended first so the
    // multiply is carried out at 2*BITS.
    function automatic logic signed [2*BITS-1:0] mul_full(
        input logic signed [BITS-1:0] a,
        input logic signed [BITS-1:0] b
    );
        logic signed [2*BITS-1:0] ax;
        logic signed [2*BITS-1:0] bx;
        ax = {{BITS{a[BITS-1]}}, a};
        bx = {{BITS{b[BITS-1]}}, b};
        return ax * bx;
    endfunction

    // {remainder, quotient}; signed division truncates toward zero, so the
    // remainder takes the sign of the dividend.  Divide by zero yields an
    // all-ones quotient and passes the dividend through as the remainder.
    function automatic logic [2*BITS-1:0] div_rem(
        input logic signed [BITS-1:0] a,
        input logic signed [BITS-1:0] b
    );
        logic signed [BITS-1:0] q;
        logic signed [BITS-1:0] r;
        if (b == '0) begin
            return {a, {BITS{1'b1}}};
        end
        q = a / b;
        r = a % b;
        return {r, q};
    endfunction

    // Rotates use a doubled copy of the operand so no complementary shift
    // amount is needed; a zero amount naturally returns the operand.
    function automatic logic [BITS-1:0] rot_right(
        input logic [BITS-1:0] a,
        input logic [BITS-1:0] n
    );
        logic [2*BITS-1:0] t;
        t = {a, a} >> n;
        return t[BITS-1:0];
    endfunction

    function automatic logic [BITS-1:0] rot_left(
        input logic [BITS-1:0] a,
        input logic [BITS-1:0] n
    );
        logic [2*BITS-1:0] t;
        t = {a, a} << n;
        return t[2*BITS-1:BITS];
    endfunction

    // -----------------------------------------------------------------------
    // Register state
    // -----------------------------------------------------------------------
    logic [BITS-1:0]   r_gpr [REGISTERS];
    logic [BITS-1:0]   r_pc;
    logic [BITS-1:0]   r_ir;
    logic [BITS-1:0]   r_ry;
    logic [2*BITS-1:0] r_rz;
    logic [BITS-1:0]   r_mar;
    logic [BITS-1:0]   r_hi;
    logic [BITS-1:0]   r_lo;
    logic [BITS-1:0]   r_mdr;

    logic [BITS-1:0]          w_bus;
    logic [2*BITS-1:0]        w_c;
    logic signed [BITS-1:0]   w_a_s;
    logic signed [BITS-1:0]   w_b_s;
    logic [BITS-1:0]          w_shamt;

    // -----------------------------------------------------------------------
    // Bus mux: later assignments override earlier ones, so the list runs from
    // lowest to highest priority and GPRs are scanned from the top index down.
    // -----------------------------------------------------------------------
    always_comb begin
        w_bus = '0;
        if (Zlowout)  w_bus = r_rz[BITS-1:0];
        if (Zhighout) w_bus = r_rz[2*BITS-1:BITS];
        if (LOout)    w_bus = r_lo;
        if (HIout)    w_bus = r_hi;
        if (MDRout)   w_bus = r_mdr;
        if (PCout)    w_bus = r_pc;
        for (int i = REGISTERS - 1; i >= 0; i--) begin
            if (GPRout[i]) w_bus = r_gpr[i];
        end
    end

    // -----------------------------------------------------------------------
    // ALU: A = RY, B = bus
    // -----------------------------------------------------------------------
    assign w_a_s   = r_ry;
    assign w_b_s   = w_bus;
    assign w_shamt = w_bus % BITS_VAL;

    always_comb begin
        w_c = '0;
        if (IncPC) begin
            w_c[BITS-1:0] = w_bus + ONE;
        end else if (ADD) begin
            w_c[BITS-1:0] = r_ry + w_bus;
        end else if (SUB) begin
            w_c[BITS-1:0] = r_ry - w_bus;
        end else if (MUL) begin
            w_c = mul_full(w_a_s, w_b_s);
        end else if (DIV) begin
            w_c = div_rem(w_a_s, w_b_s);
        end else if (SHR) begin
            w_c[BITS-1:0] = r_ry >> w_shamt;
        end else if (SHL) begin
            w_c[BITS-1:0] = r_ry << w_shamt;
        end else if (ROR) begin
            w_c[BITS-1:0] = rot_right(r_ry, w_shamt);
        end else if (ROL) begin
            w_c[BITS-1:0] = rot_left(r_ry, w_shamt);
        end else if (AND) begin
            w_c[BITS-1:0] = r_ry & w_bus;
        end else if (OR) begin
            w_c[BITS-1:0] = r_ry | w_bus;
        end else if (NEGATE) begin
            w_c[BITS-1:0] = ~w_bus + ONE;
        end else if (NOT) begin
            w_c[BITS-1:0] = ~w_bus;
        end
    end

    // -----------------------------------------------------------------------
    // Register updates; reset takes precedence over every load enable.
    // -----------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (reset) begin
            for (int i = 0; i < REGISTERS; i++) begin
                r_gpr[i] <= '0;
            end
            r_pc  <= '0;
            r_ir  <= '0;
            r_ry  <= '0;
            r_rz  <= '0;
            r_mar <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_mdr <= '0;
        end else begin
            for (int i = 0; i < REGISTERS; i++) begin
                if (GPRin[i]) r_gpr[i] <= w_bus;
            end
            if (PCin)  r_pc  <= w_bus;
            if (IRin)  r_ir  <= w_bus;
            if (RYin)  r_ry  <= w_bus;
            if (RZin)  r_rz  <= w_c;
            if (MARin) r_mar <= w_bus;
            if (HIin)  r_hi  <= w_bus;
            if (LOin)  r_lo  <= w_bus;
            if (MDRin) r_mdr <= Read ? Mdatain : w_bus;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    for (genvar g = 0; g < REGISTERS; g++) begin : g_stream
        assign regSelectStream[BITS*g +: BITS] = r_gpr[g];
    end
    assign regSelectStream[BITS*(REGISTERS+0) +: BITS] = r_pc;
    assign regSelectStream[BITS*(REGISTERS+1) +: BITS] = r_ir;
    assign regSelectStream[BITS*(REGISTERS+2) +: BITS] = r_hi;
    assign regSelectStream[BITS*(REGISTERS+3) +: BITS] = r_lo;
    assign regSelectStream[BITS*(REGISTERS+4) +: BITS] = r_mar;
    assign regSelectStream[BITS*(REGISTERS+5) +: BITS] = r_mdr;

    assign bus    = w_bus;
    assign MARVal = r_mar;
    assign IRVal  = r_ir;
    assign LOVal  = r_lo;
    assign HIVal  = r_hi;
    assign RZVal  = r_rz;

endmodule

// File: tb/tb_datapath.sv
module tb_datapath;

    localparam int BITS = 32;
    localparam int REGS = 16;
    localparam int NSL  = REGS + 6;

    logic              Clock = 1'b0;
    logic              reset;
    logic [REGS-1:0]   GPRin, GPRout;
    logic              PCin, IRin, RYin, RZin, MARin, HIin, LOin, MDRin, Read;
    logic              MDRout, LOout, HIout, Zhighout, Zlowout, PCout;
    logic              ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT, IncPC;
    logic [BITS-1:0]   Mdatain;
    logic [BITS*NSL-1:0] regSelectStream;
    logic [BITS-1:0]   bus, MARVal, IRVal, LOVal, HIVal;
    logic [2*BITS-1:0] RZVal;

    int n_cmp = 0;
    int n_err = 0;

    datapath #(.BITS(BITS), .REGISTERS(REGS)) dut (
        .Clock(Clock), .reset(reset), .GPRin(GPRin), .PCin(PCin), .IRin(IRin),
        .RYin(RYin), .RZin(RZin), .MARin(MARin), .HIin(HIin), .LOin(LOin),
        .MDRin(MDRin), .Read(Read), .MDRout(MDRout), .LOout(LOout), .HIout(HIout),
        .Zhighout(Zhighout), .Zlowout(Zlowout), .PCout(PCout), .GPRout(GPRout),
        .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV), .SHR(SHR), .SHL(SHL),
        .ROR(ROR), .ROL(ROL), .AND(AND), .OR(OR), .NEGATE(NEGATE), .NOT(NOT),
        .IncPC(IncPC), .Mdatain(Mdatain), .regSelectStream(regSelectStream),
        .bus(bus), .MARVal(MARVal), .IRVal(IRVal), .LOVal(LOVal), .HIVal(HIVal),
        .RZVal(RZVal)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [BITS-1:0] slice(input int i);
        return regSelectStream[BITS*i +: BITS];
    endfunction

    task automatic clr();
        reset = 0; GPRin = '0; GPRout = '0;
        PCin = 0; IRin = 0; RYin = 0; RZin = 0; MARin = 0; HIin = 0; LOin = 0;
        MDRin = 0; Read = 0; MDRout = 0; LOout = 0; HIout = 0; Zhighout = 0;
        Zlowout = 0; PCout = 0;
        ADD = 0; SUB = 0; MUL = 0; DIV = 0; SHR = 0; SHL = 0; ROR = 0; ROL = 0;
        AND = 0; OR = 0; NEGATE = 0; NOT = 0; IncPC = 0;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
        clr();
    endtask

    // 0 IncPC 1 ADD 2 SUB 3 MUL 4 DIV 5 SHR 6 SHL 7 ROR 8 ROL 9 AND 10 OR 11 NEGATE 12 NOT
    task automatic set_op(input int op);
        case (op)
            0: IncPC = 1;  1: ADD = 1;  2: SUB = 1;  3: MUL = 1;  4: DIV = 1;
            5: SHR = 1;    6: SHL = 1;  7: ROR = 1;  8: ROL = 1;  9: AND = 1;
            10: OR = 1;    11: NEGATE = 1;          12: NOT = 1;
            default: ;
        endcase
    endtask

    // Memory -> MDR -> Ri
    task automatic load_reg(input int idx, input logic [BITS-1:0] val);
        Read = 1; MDRin = 1; Mdatain = val;
        tick();
        MDRout = 1; GPRin[idx] = 1;
        tick();
    endtask

    // RZ <= RY op R[breg]
    task automatic alu(input int op, input int breg);
        set_op(op); GPRout[breg] = 1; RZin = 1;
        tick();
    endtask

    initial begin : main
        int ops[4];
        logic [BITS-1:0] sh_exp[4];
        ops = '{5, 6, 7, 8};
        sh_exp = '{32'h40000000, 32'h00000002, 32'hC0000000, 32'h00000003};

        clr(); Mdatain = '0;
        reset = 1;
        tick();
        for (int i = 0; i < NSL; i++) chk($sformatf("rst_slice%0d", i), 64'(slice(i)), 64'h0);
        chk("rst_rz", RZVal, 64'h0);
        chk("rst_bus", 64'(bus), 64'h0);

        // Load path
        load_reg(2, 32'h22);
        load_reg(4, 32'h24);
        load_reg(5, 32'h26);
        chk("ld_r2", 64'(slice(2)), 64'h22);
        chk("ld_r4", 64'(slice(4)), 64'h24);
        chk("ld_r5", 64'(slice(5)), 64'h26);

        // Fetch
        PCout = 1; MARin = 1; IncPC = 1; RZin = 1;
        tick();
        chk("fetch_mar", 64'(MARVal), 64'h0);
        chk("fetch_rz", RZVal, 64'h1);
        Zlowout = 1; PCin = 1;
        tick();
        chk("fetch_pc", 64'(slice(REGS)), 64'h1);
        Read = 1; MDRin = 1; Mdatain = 32'h4A920000;
        tick();
        MDRout = 1; IRin = 1;
        tick();
        chk("fetch_ir", 64'(IRVal), 64'h4A920000);
        chk("fetch_ir_slice", 64'(slice(REGS+1)), 64'h4A920000);

        // AND R5,R2,R4
        GPRout[2] = 1; RYin = 1;
        tick();
        alu(9, 4);
        chk("and_rz", RZVal, 64'h20);
        Zlowout = 1; GPRin[5] = 1;
        tick();
        chk("and_r5", 64'(slice(5)), 64'h20);

        // Bus priority
        GPRout[2] = 1; GPRout[4] = 1; PCout = 1; #1;
        chk("prio_gpr", 64'(bus), 64'h22);
        clr(); PCout = 1; MDRout = 1; #1;
        chk("prio_pc", 64'(bus), 64'h1);
        clr(); MDRout = 1; HIout = 1; #1;
        chk("prio_mdr", 64'(bus), 64'h4A920000);
        clr(); Zhighout = 1; Zlowout = 1; #1;
        chk("prio_zhigh", 64'(bus), 64'h0);
        clr(); #1;
        chk("bus_idle", 64'(bus), 64'h0);

        // MUL / DIV
        load_reg(6, 32'hFFFFFFFA);
        load_reg(7, 32'h4);
        load_reg(8, 32'h0);
        GPRout[6] = 1; RYin = 1;
        tick();
        alu(3, 7);
        chk("mul", RZVal, 64'hFFFFFFFF_FFFFFFE8);
        alu(4, 7);
        chk("div", RZVal, 64'hFFFFFFFE_FFFFFFFF);
        alu(4, 8);
        chk("div0", RZVal, 64'hFFFFFFFA_FFFFFFFF);
        Zhighout = 1; HIin = 1;
        tick();
        Zlowout = 1; LOin = 1;
        tick();
        chk("hi", 64'(HIVal), 64'hFFFFFFFA);
        chk("lo", 64'(LOVal), 64'hFFFFFFFF);

        // Shift / rotate, B = 1 and B = 33
        load_reg(9, 32'h80000001);
        load_reg(10, 32'h1);
        load_reg(11, 32'd33);
        GPRout[9] = 1; RYin = 1;
        tick();
        for (int k = 0; k < 4; k++) begin
            alu(ops[k], 10);
            chk($sformatf("shift%0d_b1", ops[k]), RZVal, 64'(sh_exp[k]));
            alu(ops[k], 11);
            chk($sformatf("shift%0d_b33", ops[k]), RZVal, 64'(sh_exp[k]));
        end

        // Remaining ops with A = 0x80000001, B = 1
        alu(1, 10);  chk("add", RZVal, 64'h80000002);
        alu(1, 6);   chk("add_wrap", RZVal, 64'h7FFFFFFB);
        alu(2, 10);  chk("sub", RZVal, 64'h80000000);
        alu(10, 10); chk("or", RZVal, 64'h80000001);
        alu(11, 10); chk("negate", RZVal, 64'hFFFFFFFF);
        alu(12, 10); chk("not", RZVal, 64'hFFFFFFFE);
        alu(0, 10);  chk("incpc", RZVal, 64'h2);
        ADD = 1; SUB = 1; GPRout[10] = 1; RZin = 1;
        tick();
        chk("op_prio", RZVal, 64'h80000002);
        GPRout[10] = 1; RZin = 1;
        tick();
        chk("no_op", RZVal, 64'h0);

        // Simultaneous drive and load of MDR
        MDRout = 1; MDRin = 1; Read = 1; Mdatain = 32'h55; #1;
        chk("same_cyc_bus", 64'(bus), 64'd33);
        tick();
        chk("same_cyc_mdr", 64'(slice(REGS+5)), 64'h55);

        // Reset mid-operation with every load enable high
        reset = 1; GPRin = '1; PCin = 1; IRin = 1; RYin = 1; RZin = 1; MARin = 1;
        HIin = 1; LOin = 1; MDRin = 1; Read = 1; Mdatain = 32'hFFFF; ADD = 1;
        GPRout[9] = 1;
        tick();
        for (int i = 0; i < NSL; i++) chk($sformatf("rst2_slice%0d", i), 64'(slice(i)), 64'h0);
        chk("rst2_rz", RZVal, 64'h0);
        chk("rst2_bus", 64'(bus), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
